// File: rtl/jedro_1_checker_pkg.sv
// Shared types for the jedro_1 end-of-program checker.
package jedro_1_checker_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        READ  = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } chk_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ILLEGAL = 2'd1,
        HALT    = 2'd2,
        TIMEOUT = 2'd3
    } stop_reason_e;

endpackage

// File: rtl/jedro_1_prog_checker.sv
// End-of-program checker: run until illegal/halt/limit, drain, then compare regfile slots.
// Latency: DRAIN_CYCLES after stop, then 2 cycles per enabled slot, 1 per disabled; start_i ignored while busy.
module jedro_1_prog_checker
    import jedro_1_checker_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int NUM_CHECKS      = 4,
    parameter int MAX_CYCLES      = 32,
    parameter int DRAIN_CYCLES    = 3,
    parameter int CNT_WIDTH       = 16,
    parameter bit TIMEOUT_IS_FAIL = 1'b0,
    localparam int FI_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic                               illegal_instr_i,
    input  logic                               halt_i,
    input  logic [NUM_CHECKS-1:0]              chk_en_i,
    input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] chk_addr_i,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]   chk_data_i,
    output logic [REG_ADDR_WIDTH-1:0]          rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]              rf_rdata_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               pass_o,
    output logic                               fail_o,
    output logic [1:0]                         stop_reason_o,
    output logic [FI_W-1:0]                    fail_idx_o,
    output logic [DATA_WIDTH-1:0]              fail_val_o,
    output logic [CNT_WIDTH-1:0]               cycles_o
);

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [FI_W-1:0]      LAST_IDX   = FI_W'(NUM_CHECKS - 1);
    localparam logic [DC_W-1:0]      DRAIN_LAST = DC_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CYC_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);

    chk_state_e                state;
    stop_reason_e              reason;
    logic [FI_W-1:0]           idx;
    logic [DC_W-1:0]           dcnt;
    logic [REG_ADDR_WIDTH-1:0] raddr_q;

    logic                      slot_en;
    logic [REG_ADDR_WIDTH-1:0] slot_addr;
    logic [DATA_WIDTH-1:0]     slot_data;
    logic                      timeout_fail;

    assign slot_en      = chk_en_i[idx];
    assign slot_addr    = chk_addr_i[idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign slot_data    = chk_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
    assign timeout_fail = TIMEOUT_IS_FAIL && (reason == TIMEOUT);

    // Address is presented during READ so synchronous-read data lands in CMP.
    assign rf_raddr_o    = (state == READ && slot_en) ? slot_addr : raddr_q;
    assign busy_o        = (state == RUN) || (state == DRAIN) || (state == READ) || (state == CMP);
    assign done_o        = (state == DONE);
    assign stop_reason_o = reason;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            reason     <= NONE;
            idx        <= '0;
            dcnt       <= '0;
            raddr_q    <= '0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            fail_idx_o <= '0;
            fail_val_o <= '0;
            cycles_o   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state      <= RUN;
                        reason     <= NONE;
                        idx        <= '0;
                        dcnt       <= '0;
                        pass_o     <= 1'b0;
                        fail_o     <= 1'b0;
                        fail_idx_o <= '0;
                        fail_val_o <= '0;
                        cycles_o   <= '0;
                    end
                end
                RUN: begin
                    if (cycles_o != '1) cycles_o <= cycles_o + CNT_WIDTH'(1);
                    if (illegal_instr_i || halt_i || cycles_o == CYC_LAST) begin
                        reason <= illegal_instr_i ? ILLEGAL : (halt_i ? HALT : TIMEOUT);
                        state  <= (DRAIN_CYCLES == 0) ? READ : DRAIN;
                        dcnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (dcnt == DRAIN_LAST) state <= READ;
                    else                    dcnt  <= dcnt + DC_W'(1);
                end
                READ: begin
                    if (slot_en) begin
                        raddr_q <= slot_addr;
                        state   <= CMP;
                    end else if (idx == LAST_IDX) begin
                        state  <= DONE;
                        pass_o <= !timeout_fail;
                        fail_o <= timeout_fail;
                    end else begin
                        idx <= idx + FI_W'(1);
                    end
                end
                CMP: begin
                    if (rf_rdata_i != slot_data) begin
                        fail_idx_o <= idx;
                        fail_val_o <= rf_rdata_i;
                        pass_o     <= 1'b0;
                        fail_o     <= 1'b1;
                        state      <= DONE;
                    end else if (idx == LAST_IDX) begin
                        pass_o <= !timeout_fail;
                        fail_o <= timeout_fail;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + FI_W'(1);
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_prog_checker.sv
// Scoreboard bench: two checkers (timeout pass / timeout fail) share stimulus and a modelled regfile.
module tb_jedro_1_prog_checker;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         illegal = 1'b0;
    logic         halt = 1'b0;
    logic [3:0]   chk_en = '0;
    logic [19:0]  chk_addr = '0;
    logic [127:0] chk_data = '0;

    logic [4:0]   raddr0, raddr1;
    logic [31:0]  rdata0 = '0, rdata1 = '0;
    logic         busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
    logic [1:0]   reason0, reason1, fidx0, fidx1;
    logic [31:0]  fval0, fval1;
    logic [15:0]  cycles0, cycles1;

    logic [31:0]  regs [32];

    int vec = 0;
    int err = 0;

    typedef struct {
        bit          pass;
        bit          fail;
        bit          fail1;
        logic [1:0]  reason;
        logic [15:0] cycles;
        logic [1:0]  fidx;
        logic [31:0] fval;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata0 <= regs[raddr0];
        rdata1 <= regs[raddr1];
    end

    jedro_1_prog_checker u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .illegal_instr_i(illegal), .halt_i(halt),
        .chk_en_i(chk_en), .chk_addr_i(chk_addr), .chk_data_i(chk_data),
        .rf_raddr_o(raddr0), .rf_rdata_i(rdata0), .busy_o(busy0), .done_o(done0),
        .pass_o(pass0), .fail_o(fail0), .stop_reason_o(reason0), .fail_idx_o(fidx0),
        .fail_val_o(fval0), .cycles_o(cycles0)
    );

    jedro_1_prog_checker #(.TIMEOUT_IS_FAIL(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .illegal_instr_i(illegal), .halt_i(halt),
        .chk_en_i(chk_en), .chk_addr_i(chk_addr), .chk_data_i(chk_data),
        .rf_raddr_o(raddr1), .rf_rdata_i(rdata1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .fail_o(fail1), .stop_reason_o(reason1), .fail_idx_o(fidx1),
        .fail_val_o(fval1), .cycles_o(cycles1)
    );

    task automatic set_slot(input int k, input bit en, input logic [4:0] a, input logic [31:0] d);
        chk_en[k]           = en;
        chk_addr[k*5 +: 5]  = a;
        chk_data[k*32 +: 32] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        vec++; if (busy0 !== 1'b0)   begin err++; $display("FAIL %s busy: got %b want 0", tag, busy0); end
        vec++; if (done0 !== 1'b0)   begin err++; $display("FAIL %s done: got %b want 0", tag, done0); end
        vec++; if (pass0 !== 1'b0 || fail0 !== 1'b0) begin err++; $display("FAIL %s pass/fail: got %b/%b want 0/0", tag, pass0, fail0); end
        vec++; if (reason0 !== 2'd0) begin err++; $display("FAIL %s reason: got %0d want 0", tag, reason0); end
        vec++; if (cycles0 !== 16'd0) begin err++; $display("FAIL %s cycles: got %0d want 0", tag, cycles0); end
        vec++; if (fidx0 !== 2'd0 || fval0 !== 32'd0) begin err++; $display("FAIL %s fail_idx/val: got %0d/%h want 0/0", tag, fidx0, fval0); end
        vec++; if (raddr0 !== 5'd0)  begin err++; $display("FAIL %s raddr: got %0d want 0", tag, raddr0); end
    endtask

    // stop_at: run cycle in which illegal/halt is raised (31 with both low = timeout).
    task automatic run_and_check(input string tag, input int stop_at, input bit ill, input bit hlt,
                                 input int poke_at);
        exp_t e, got;
        int   chk = 0;
        bit   mis = 0;
        int   lat = 0;
        e.fidx = 2'd0;
        e.fval = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (!mis) begin
                if (chk_en[k]) begin
                    chk += 2;
                    if (regs[chk_addr[k*5 +: 5]] !== chk_data[k*32 +: 32]) begin
                        mis    = 1;
                        e.fidx = k[1:0];
                        e.fval = regs[chk_addr[k*5 +: 5]];
                    end
                end else begin
                    chk += 1;
                end
            end
        end
        e.reason = ill ? 2'd1 : (hlt ? 2'd2 : 2'd3);
        e.cycles = 16'(stop_at + 1);
        e.fail   = mis;
        e.pass   = !mis;
        e.fail1  = mis || (e.reason == 2'd3);
        e.lat    = 3 + chk;
        sb.push_back(e);

        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        vec++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin err++; $display("FAIL %s run_entry busy/done: got %b/%b want 1/0", tag, busy0, done0); end
        vec++; if (cycles0 !== 16'd0) begin err++; $display("FAIL %s run_entry cycles: got %0d want 0", tag, cycles0); end

        for (int c = 0; c < stop_at; c++) begin
            if (c == poke_at) start = 1'b1;
            @(posedge clk) #1;
            start = 1'b0;
        end
        illegal = ill;
        halt    = hlt;
        @(posedge clk) #1;
        illegal = 1'b0;
        halt    = 1'b0;
        vec++; if (cycles0 !== e.cycles) begin err++; $display("FAIL %s stop cycles: got %0d want %0d", tag, cycles0, e.cycles); end
        vec++; if (reason0 !== e.reason) begin err++; $display("FAIL %s stop reason: got %0d want %0d", tag, reason0, e.reason); end
        vec++; if (busy0 !== 1'b1) begin err++; $display("FAIL %s drain busy: got %b want 1", tag, busy0); end

        while (done0 !== 1'b1 && lat < 100) begin
            @(posedge clk) #1;
            lat++;
        end
        got = sb.pop_front();
        vec++; if (lat != got.lat) begin err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, got.lat); end
        vec++; if (pass0 !== got.pass || fail0 !== got.fail) begin err++; $display("FAIL %s pass/fail: got %b/%b want %b/%b", tag, pass0, fail0, got.pass, got.fail); end
        vec++; if (done1 !== 1'b1 || fail1 !== got.fail1 || pass1 !== !got.fail1) begin err++; $display("FAIL %s tif dut done/pass/fail: got %b/%b/%b want 1/%b/%b", tag, done1, pass1, fail1, !got.fail1, got.fail1); end
        vec++; if (reason0 !== got.reason || cycles0 !== got.cycles) begin err++; $display("FAIL %s done reason/cycles: got %0d/%0d want %0d/%0d", tag, reason0, cycles0, got.reason, got.cycles); end
        if (got.fail) begin
            vec++; if (fidx0 !== got.fidx || fval0 !== got.fval) begin err++; $display("FAIL %s fail_idx/val: got %0d/%h want %0d/%h", tag, fidx0, fval0, got.fidx, got.fval); end
        end
        @(posedge clk) #1;
        vec++; if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== got.pass) begin err++; $display("FAIL %s done hold: got done=%b busy=%b pass=%b want 1/0/%b", tag, done0, busy0, pass0, got.pass); end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset_asserted");
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_pass_illegal();
        chk_en = '0;
        set_slot(0, 1'b1, 5'd5, 32'd5);
        run_and_check("pass_illegal", 10, 1'b1, 1'b0, -1);
    endtask

    task automatic test_mismatch();
        chk_en = '0;
        set_slot(0, 1'b1, 5'd5, 32'd6);
        run_and_check("mismatch_slot0", 7, 1'b0, 1'b1, -1);
        set_slot(0, 1'b1, 5'd5, 32'd5);
        set_slot(1, 1'b1, 5'd9, 32'h1234);
        set_slot(2, 1'b1, 5'd3, 32'h5678);
        run_and_check("mismatch_slot1", 2, 1'b1, 1'b0, -1);
    endtask

    task automatic test_timeout();
        chk_en = '0;
        set_slot(0, 1'b1, 5'd5, 32'd5);
        run_and_check("timeout", 31, 1'b0, 1'b0, -1);
    endtask

    task automatic test_mixed_slots();
        chk_en = '0;
        set_slot(0, 1'b1, 5'd5, 32'd5);
        set_slot(1, 1'b0, 5'd7, 32'hdead);
        set_slot(2, 1'b1, 5'd0, 32'd0);
        set_slot(3, 1'b0, 5'd8, 32'hbeef);
        run_and_check("mixed_slots", 4, 1'b1, 1'b1, -1);
        chk_en = '0;
        run_and_check("no_slots", 2, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_drain();
        chk_en = '0;
        set_slot(0, 1'b1, 5'd5, 32'd5);
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (3) @(posedge clk) #1;
        illegal = 1'b1;
        @(posedge clk) #1;
        illegal = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_in_drain");
        @(posedge clk) #1;
        rst = 1'b0;
        run_and_check("after_reset", 6, 1'b0, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        chk_en = '0;
        set_slot(0, 1'b1, 5'd5, 32'd5);
        set_slot(3, 1'b1, 5'd12, 32'h10c);
        run_and_check("start_while_busy", 12, 1'b0, 1'b1, 5);
        run_and_check("rerun_from_done", 3, 1'b1, 1'b0, -1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        regs[0] = 32'd0;
        regs[5] = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_pass_illegal();
        test_mismatch();
        test_timeout();
        test_mixed_slots();
        test_reset_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget, vectors=%0d", vec);
        $fatal(1);
    end

endmodule
